// File: rtl/fwrisc_mds_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fwrisc_mds_pkg
// Purpose : Shared definitions for the mul/div/shift unit and its arbiter:
//           opcode encodings, the opcode count that bounds legal ops, and the
//           arbiter state type.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package fwrisc_mds_pkg;

    // Opcodes understood by fwrisc_mul_div_shift. Anything >= OP_NUM_MDS
    // is illegal and must never reach the unit.
    localparam logic [3:0] OP_SLL     = 4'd0;
    localparam logic [3:0] OP_SRL     = 4'd1;
    localparam logic [3:0] OP_SRA     = 4'd2;
    localparam logic [3:0] OP_MUL     = 4'd3;
    localparam logic [3:0] OP_MULH    = 4'd4;
    localparam logic [3:0] OP_MULS    = 4'd5;
    localparam logic [3:0] OP_MULSU   = 4'd6;
    localparam logic [3:0] OP_DIV     = 4'd7;
    localparam logic [3:0] OP_REM     = 4'd8;
    localparam logic [3:0] OP_NUM_MDS = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } mds_arb_state_t;

    function automatic logic mds_op_legal(input logic [3:0] op);
        return (op < OP_NUM_MDS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwrisc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fwrisc_rr_arbiter
// Purpose : Combinational round-robin picker. Searches the request vector
//           starting one past the previous winner and wrapping modulo N.
// Ports   : req         - request vector
//           last_grant  - index of the previous winner
//           grant       - one-hot winner (all zero when no request)
//           grant_idx   - binary index of the winner
//           grant_valid - at least one request present
// Revision: 1.0  initial release
// ============================================================================
module fwrisc_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] w_cand;

    // Walk the N candidates in priority order; the first requester found
    // wins. The modulo handles non-power-of-two N.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(last_grant) + k) % N);
            if (!grant_valid && req[w_cand]) begin
                grant_valid   = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwrisc_mds_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fwrisc_mds_arbiter
// Purpose : Shares one multi-cycle mul/div/shift unit between N_REQ
//           requesters. Round-robin valid/ready accept, single-cycle issue
//           pulse, completion wait with watchdog, tagged response with
//           backpressure, and a drain phase after a lost completion.
// Ports   : clock, reset           - clock, synchronous active-high reset
//           req_valid/ready        - per-requester request handshake
//           req_a/req_b/req_op     - packed per-requester operands/opcode
//           rsp_valid/ready        - per-requester response handshake
//           rsp_data/rsp_err       - shared response payload
//           mds_in_a/b, mds_op,
//           mds_in_valid           - to the unit
//           mds_out, mds_out_valid - from the unit
// Revision: 1.0  initial release
// ============================================================================
module fwrisc_mds_arbiter
    import fwrisc_mds_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 40
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    input  logic [N_REQ*4-1:0]   req_op,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic [31:0]          mds_in_a,
    output logic [31:0]          mds_in_b,
    output logic [3:0]           mds_op,
    output logic                 mds_in_valid,
    input  logic [31:0]          mds_out,
    input  logic                 mds_out_valid
);

    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    mds_arb_state_t r_state;
    mds_arb_state_t w_state_nxt;

    logic [IW-1:0]  r_last_grant;
    logic [IW-1:0]  r_owner;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [3:0]     r_op;
    logic [31:0]    r_rsp_data;
    logic           r_rsp_err;
    logic           r_drain_pend;
    logic [WDW-1:0] r_wdog;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_grant_idx;
    logic             w_grant_valid;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic [3:0]       w_sel_op;
    logic             w_op_legal;
    logic             w_rsp_hs;
    logic             w_wdog_exp;

    fwrisc_rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (r_last_grant),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    // Payload of the winning requester.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_idx == IW'(i)) begin
                w_sel_a  = req_a[i*32 +: 32];
                w_sel_b  = req_b[i*32 +: 32];
                w_sel_op = req_op[i*4 +: 4];
            end
        end
    end

    assign w_op_legal = mds_op_legal(w_sel_op);
    // Only the owner's rsp_ready matters; the others are ignored.
    assign w_rsp_hs   = (r_state == ST_RESP) && rsp_ready[r_owner];
    assign w_wdog_exp = (r_wdog == WDW'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_valid) w_state_nxt = w_op_legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (mds_out_valid || w_wdog_exp) w_state_nxt = ST_RESP;
            ST_RESP:  if (w_rsp_hs) w_state_nxt = r_drain_pend ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (mds_out_valid) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IW'(N_REQ - 1);
            r_owner      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_drain_pend <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_last_grant <= w_grant_idx;
                        r_owner      <= w_grant_idx;
                        r_drain_pend <= 1'b0;
                        if (w_op_legal) begin
                            r_a  <= w_sel_a;
                            r_b  <= w_sel_b;
                            r_op <= w_sel_op;
                        end else begin
                            // Rejected without touching the unit inputs.
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: r_wdog <= '0;
                ST_WAIT: begin
                    if (mds_out_valid) begin
                        r_rsp_data <= mds_out;
                        r_rsp_err  <= 1'b0;
                    end else if (w_wdog_exp) begin
                        // The unit may still complete later; drain it before
                        // another in_valid can be issued.
                        r_rsp_data   <= '0;
                        r_rsp_err    <= 1'b1;
                        r_drain_pend <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == ST_IDLE) req_ready = w_grant;
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == ST_RESP) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (r_owner == IW'(i)) rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    // Operands/op stay on the captured values for the whole operation; the
    // unit samples op live while dividing.
    assign mds_in_a     = r_a;
    assign mds_in_b     = r_b;
    assign mds_op       = r_op;
    assign mds_in_valid = (r_state == ST_ISSUE);

endmodule
`default_nettype wire

// File: doc/fwrisc_mds_arbiter.md
# fwrisc_mds_arbiter

Shares one multi-cycle `fwrisc_mul_div_shift` unit between `N_REQ` requesters (e.g. integer pipeline and a coprocessor/debug port). It accepts requests by round-robin valid/ready handshake, sequences the unit with a single `in_valid` pulse, waits for `out_valid`, and returns a tagged response with backpressure. A watchdog flags lost completions. Illegal opcodes are rejected without touching the unit.

## Interface
- `N_REQ`, 2: number of requesters; 2..8.
- `TIMEOUT`, 40: cycles in WAIT without `mds_out_valid` before an error response; must exceed worst-case unit latency (34).

- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: per-requester request.
- `req_ready` out N_REQ: one-hot accept; request transfers when `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b` in N_REQ*32: operands, slice i = requester i.
- `req_op` in N_REQ*4: opcode per requester.
- `rsp_valid` out N_REQ: one-hot response to the owning requester.
- `rsp_ready` in N_REQ: per-requester response accept.
- `rsp_data` out 32: result.
- `rsp_err` out 1: 1 = illegal op or timeout; `rsp_data` = 0 then.
- `mds_in_a`, `mds_in_b` out 32: to unit `in_a`/`in_b`.
- `mds_op` out 4: to unit `op`.
- `mds_in_valid` out 1: to unit `in_valid`.
- `mds_out` in 32, `mds_out_valid` in 1: from unit.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: if any `req_valid`, grant by round-robin starting at `last_grant+1` (mod N_REQ); `req_ready[g]`=1 combinationally this cycle only; capture a/b/op/owner. Legal op (< OP_NUM_MDS = 9) -> ISSUE; illegal op -> RESP with `rsp_err`=1, `rsp_data`=0. `last_grant` <= g on every accept.
- `req_ready` is 0 in every state other than IDLE.
- ISSUE: `mds_in_valid`=1 for exactly this cycle; -> WAIT, watchdog cleared.
- WAIT: `mds_op`, `mds_in_a`, `mds_in_b` held at captured values (unit reads `op` live during divide). On `mds_out_valid`: capture `mds_out`, `rsp_err`=0 -> RESP. Watchdog reaching TIMEOUT: `rsp_err`=1, `rsp_data`=0 -> RESP, mark drain pending.
- RESP: `rsp_valid[owner]`=1, data/err stable until `rsp_ready[owner]`. On handshake -> DRAIN if drain pending, else IDLE. `rsp_ready` of other requesters ignored.
- DRAIN: wait for `mds_out_valid` (no timeout), discard it -> IDLE. Prevents a new `in_valid` while the unit is still working.
- `mds_out_valid` outside WAIT/DRAIN ignored.
- Reset (any state, mid-operation included): state IDLE, `last_grant` = N_REQ-1 (requester 0 wins first), drain pending 0, watchdog 0. Outputs after reset: `req_ready`=0 until a `req_valid`, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mds_in_valid`=0, `mds_op`=0, `mds_in_a`=`mds_in_b`=0. The unit shares `reset`, so no drain is required after reset.

## Timing
- Accept cycle T; `mds_in_valid` at T+1; for shifts by s, unit `out_valid` at T+s+3; `rsp_valid` at T+s+4. Mul/div: `rsp_valid` at T+35.
- `rsp_valid` and `rsp_ready` both high in cycle R: response transfers in R; earliest next `req_ready` is R+1 (IDLE), or after drain.
- Illegal op: accept T, `rsp_valid` at T+1.
- Watchdog counts WAIT cycles; error when count == TIMEOUT, i.e. `rsp_valid` at T+2+TIMEOUT+1.
- One outstanding operation; no pipelining.

## Structure
- Shared package `fwrisc_mds_pkg`: OP_SLL..OP_REM and OP_NUM_MDS constants (single source for unit and arbiter), state enum type.
- Sub-module `fwrisc_rr_arbiter` (N parameter): request vector + last grant -> one-hot grant and index; combinational only, reusable.

## Test plan
- Single SLL: req0 a=1, b=4, op=0 -> `mds_in_valid` one cycle after accept; `rsp_valid[0]` with `rsp_data`=16, `rsp_err`=0, 8 cycles after accept.
- Contention: req0 and req1 valid continuously, SRL a=0x80 b=3 -> grants alternate 0,1,0,1; each response 0x10 to the correct owner only.
- Backpressure: hold `rsp_ready[0]`=0 for 10 cycles -> `rsp_valid[0]`/`rsp_data` stable; `req_ready` stays 0; release -> IDLE next cycle.
- Illegal op: req1 op=12 -> `rsp_valid[1]` at T+1, `rsp_err`=1, `rsp_data`=0, `mds_in_valid` never asserted.
- Timeout: stub unit never raises `out_valid`, TIMEOUT=5 -> error response at T+8; then the arbiter stays in DRAIN (no `req_ready`) until stub pulses `out_valid`.
- Reset in WAIT: assert `reset` mid-divide -> all outputs at reset values next cycle; first new request from req0 granted and completes correctly.
